branch_resolver: RTL and testbench
==================================

# branch_resolver

Back-end branch resolution unit: accepts one conditional branch per cycle from the branch-unit reservation station and evaluates its condition and target. Checks the outcome against the frontend's prediction and returns a `resolution_t` record to the frontend/BPU update path. A 2-entry output FIFO decouples execution from frontend back-pressure, and a flush input discards in-flight results on pipeline squash.

## Interface
- `XLEN`, 64: datapath and PC width.
- `ROB_IDX_LEN`, 2: ROB tag width, equal to clog2(ROB_DEPTH).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  synchronous squash of all held results.
- `valid_i`  in  1  branch operation present.
- `ready_o`  out  1  unit can accept; equals `!rst_i && count<2`, with no path from `res_ready_i`.
- `branch_type_i`  in  3  `branch_type_t` (BEQ..BGEU).
- `rs1_value_i`, `rs2_value_i`  in  XLEN  operands.
- `pc_i`  in  XLEN  branch PC.
- `imm_i`  in  13  B-type offset, bit 0 always 0, two's complement.
- `pred_taken_i`  in  1  frontend prediction direction.
- `pred_target_i`  in  XLEN  frontend predicted target.
- `rob_idx_i`  in  ROB_IDX_LEN  ROB tag.
- `res_valid_o`  out  1  FIFO head valid.
- `res_ready_i`  in  1  consumer accepts head.
- `res_o`  out  `resolution_t`  head record; all-zero when empty.
- `rob_idx_o`  out  ROB_IDX_LEN  head tag; 0 when empty.

## Operation
- Accept on `valid_i && ready_o`; push computed record at that edge.
- `taken` by type:
  - BEQ: `rs1==rs2`.
  - BNE: `rs1!=rs2`.
  - BLT/BGE: signed less-than / greater-or-equal.
  - BLTU/BGEU: unsigned less-than / greater-or-equal.
  - Codes 6,7: `taken=0`.
- `target = taken ? pc_i + sext(imm_i) : pc_i + 4`, computed modulo 2^XLEN; wrap-around is silent.
- `mispredict = (taken != pred_taken_i) || (taken && target != pred_target_i)`.
- Record fields: `pc=pc_i`, `target`, `taken`, `valid=1`, `mispredict`, plus the tag.
- Pop on `res_valid_o && res_ready_i`.
- Push and pop in the same cycle with count=1: count stays 1, new entry becomes head next cycle.
- FIFO order is strictly in order. Entries are never dropped except by flush or reset.
- `flush_i`: count←0 at the edge. An input accepted in the same cycle is discarded, and any pop that cycle is ignored. `ready_o` is unaffected by flush.
- `rst_i` (including mid-operation): count←0, pointers←0, stored entries zeroed.

## Timing
- Latency: accepted at edge N → visible on `res_o` with `res_valid_o=1` from cycle N+1.
- Throughput: 1/cycle while `res_ready_i=1`.
- `res_o`, `res_valid_o`, `rob_idx_o` are driven from registers only.
- `ready_o` is combinational from count and `rst_i` only.
- Reset values: `res_valid_o=0`, `res_o=0`, `rob_idx_o=0`. `ready_o=0` while `rst_i=1`, and 1 on the first cycle after reset.
- Full: count=2 → `ready_o=0`, so no push while full; a pop at full frees a slot visible the next cycle.
- Empty: pop attempts are ignored.

## Structure
- `branch_type_t`, `resolution_t`, `XLEN`, `ROB_DEPTH` live in `len5_pkg`.
- Add a new typedef `bu_result_t {resolution_t res; logic [ROB_IDX_LEN-1:0] rob_idx;}` to `len5_pkg`.
- The combinational condition/target logic lives in the top module.
- One sub-module, `branch_res_fifo`:
  - 2-entry, registered output, parameterised on the entry type.
  - Ports: push/pop/flush, full/empty.

## Test plan
- Correct prediction: BEQ, rs1=rs2=5, pc=0x1000, imm=0x10, pred taken to 0x1010 → next cycle `res_valid_o=1`, taken=1, target=0x1010, mispredict=0.
- Signed vs unsigned: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, pc=0x2000, imm=0x20, pred taken to 0x2020.
  - BLT → taken=1, mispredict=0.
  - BLTU → taken=0, target=0x2004, mispredict=1.
- Back-pressure: `res_ready_i=0`, three back-to-back BNE (tags 0,1,2) → `ready_o` falls after the second accept and the third is held. Raising `res_ready_i` drains tags 0,1,2 in order.
- Flush: 2 entries held, `flush_i=1` with a concurrent accepted input → next cycle `res_valid_o=0`, count=0; the input never appears.
- Wrap and negative offsets:
  - pc=0xFFFF_FFFF_FFFF_FFF8, imm=0x10, taken → target=0x8.
  - pc=0x1800, imm=-0x1000 (0x1000 as 13-bit), taken → target=0x800.
- Reset and illegal type: `rst_i` asserted with 2 entries held → outputs zero next cycle. Type code 6 → taken=0, target=pc+4.

Source files
------------

// File: rtl/len5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : len5_pkg
//  Purpose  : Shared types and widths for the LEN5 branch resolution path.
//             Holds the branch condition encoding, the resolution record
//             returned to the frontend/BPU, and the FIFO entry type that
//             pairs a resolution with its ROB tag.
//  Revision : 1.0 - initial release
// ============================================================================
package len5_pkg;

  localparam int XLEN        = 64;
  localparam int ROB_DEPTH   = 4;
  localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);

  // Conditional branch kinds; codes 6 and 7 are unused and resolve not-taken.
  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5
  } branch_type_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            valid;
    logic            mispredict;
  } resolution_t;

  typedef struct packed {
    resolution_t            res;
    logic [ROB_IDX_LEN-1:0] rob_idx;
  } bu_result_t;

endpackage
`default_nettype wire

// File: rtl/branch_res_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : branch_res_fifo
//  Purpose  : Two-entry in-order FIFO with register-sourced head output,
//             parameterised on the stored entry type.
//  Ports    : clk_i, rst_i  - clock, synchronous active-high reset
//             flush_i       - drop all held entries (and any same-cycle push/pop)
//             push_i/data_i - write an entry (caller must not push when full)
//             pop_i         - retire the head (ignored when empty)
//             data_o        - head entry, all-zero when empty
//             full_o/empty_o- occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module branch_res_fifo #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  T           r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == 2'd2);
  assign empty_o = (r_count == 2'd0);

  // Guards keep the occupancy counter consistent even if a caller misbehaves.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Head is gated to zero when empty so a stale popped entry never shows.
  always_comb begin
    data_o = '0;
    if (!empty_o) begin
      data_o = r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Storage contents are left as-is; the zero count hides them.
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolver
//  Purpose  : Back-end conditional branch resolution. Evaluates the branch
//             condition and target, compares against the frontend prediction
//             and queues a resolution record (plus ROB tag) in a 2-entry FIFO
//             towards the frontend/BPU update path.
//  Ports    : clk_i, rst_i, flush_i         - clock, sync reset, squash
//             valid_i / ready_o             - issue handshake
//             branch_type_i, rs1/rs2_value_i, pc_i, imm_i,
//             pred_taken_i, pred_target_i, rob_idx_i - branch operation
//             res_valid_o / res_ready_i     - result handshake
//             res_o, rob_idx_o              - head record and tag
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolver
  import len5_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2:0]             branch_type_i,
  input  logic [XLEN-1:0]        rs1_value_i,
  input  logic [XLEN-1:0]        rs2_value_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [12:0]            imm_i,
  input  logic                   pred_taken_i,
  input  logic [XLEN-1:0]        pred_target_i,
  input  logic [ROB_IDX_LEN-1:0] rob_idx_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output resolution_t            res_o,
  output logic [ROB_IDX_LEN-1:0] rob_idx_o
);

  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_imm_sext;
  logic            w_mispredict;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  bu_result_t      w_push_data;
  bu_result_t      w_head;

  always_comb begin
    w_taken = 1'b0;
    case (branch_type_t'(branch_type_i))
      BEQ:     w_taken = (rs1_value_i == rs2_value_i);
      BNE:     w_taken = (rs1_value_i != rs2_value_i);
      BLT:     w_taken = ($signed(rs1_value_i) <  $signed(rs2_value_i));
      BGE:     w_taken = ($signed(rs1_value_i) >= $signed(rs2_value_i));
      BLTU:    w_taken = (rs1_value_i <  rs2_value_i);
      BGEU:    w_taken = (rs1_value_i >= rs2_value_i);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_imm_sext = {{(XLEN-13){imm_i[12]}}, imm_i};
  // Both adds wrap modulo 2^XLEN by construction.
  assign w_target   = w_taken ? (pc_i + w_imm_sext) : (pc_i + XLEN'(4));

  // The predicted target only matters when the branch is actually taken.
  assign w_mispredict = (w_taken != pred_taken_i) ||
                        (w_taken && (w_target != pred_target_i));

  // No path from res_ready_i: a pop at full only frees a slot next cycle.
  assign ready_o  = !rst_i && !w_full;
  assign w_accept = valid_i && ready_o;

  always_comb begin
    w_push_data                = '0;
    w_push_data.res.pc         = pc_i;
    w_push_data.res.target     = w_target;
    w_push_data.res.taken      = w_taken;
    w_push_data.res.valid      = 1'b1;
    w_push_data.res.mispredict = w_mispredict;
    w_push_data.rob_idx        = rob_idx_i;
  end

  branch_res_fifo #(
    .T (bu_result_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_accept),
    .data_i  (w_push_data),
    .pop_i   (res_ready_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign res_valid_o = !w_empty;
  assign res_o       = w_head.res;
  assign rob_idx_o   = w_head.rob_idx;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolver
//  Purpose  : Directed self-checking bench for branch_resolver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;
  import len5_pkg::*;

  logic                   clk_i;
  logic                   rst_i;
  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [2:0]             branch_type_i;
  logic [XLEN-1:0]        rs1_value_i;
  logic [XLEN-1:0]        rs2_value_i;
  logic [XLEN-1:0]        pc_i;
  logic [12:0]            imm_i;
  logic                   pred_taken_i;
  logic [XLEN-1:0]        pred_target_i;
  logic [ROB_IDX_LEN-1:0] rob_idx_i;
  logic                   res_valid_o;
  logic                   res_ready_i;
  resolution_t            res_o;
  logic [ROB_IDX_LEN-1:0] rob_idx_o;

  int n_checks;
  int n_fail;

  branch_resolver dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .branch_type_i (branch_type_i),
    .rs1_value_i   (rs1_value_i),
    .rs2_value_i   (rs2_value_i),
    .pc_i          (pc_i),
    .imm_i         (imm_i),
    .pred_taken_i  (pred_taken_i),
    .pred_target_i (pred_target_i),
    .rob_idx_i     (rob_idx_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_o         (res_o),
    .rob_idx_o     (rob_idx_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] bt, input logic [XLEN-1:0] rs1,
                       input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc,
                       input logic [12:0] imm, input logic pt,
                       input logic [XLEN-1:0] ptgt,
                       input logic [ROB_IDX_LEN-1:0] tag);
    valid_i       = 1'b1;
    branch_type_i = bt;
    rs1_value_i   = rs1;
    rs2_value_i   = rs2;
    pc_i          = pc;
    imm_i         = imm;
    pred_taken_i  = pt;
    pred_target_i = ptgt;
    rob_idx_i     = tag;
  endtask

  // Full-record check against hand-computed values.
  task automatic chk_head(input string tag, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] tgt, input logic tk,
                          input logic mp, input logic [ROB_IDX_LEN-1:0] idx);
    chk({tag, ".res_valid"},  64'(res_valid_o), 64'd1);
    chk({tag, ".pc"},         res_o.pc, pc);
    chk({tag, ".target"},     res_o.target, tgt);
    chk({tag, ".taken"},      64'(res_o.taken), 64'(tk));
    chk({tag, ".valid"},      64'(res_o.valid), 64'd1);
    chk({tag, ".mispredict"}, 64'(res_o.mispredict), 64'(mp));
    chk({tag, ".rob_idx"},    64'(rob_idx_o), 64'(idx));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".res_valid"}, 64'(res_valid_o), 64'd0);
    chk({tag, ".res_pc"},    res_o.pc, 64'd0);
    chk({tag, ".res_tgt"},   res_o.target, 64'd0);
    chk({tag, ".res_flags"}, 64'({res_o.taken, res_o.valid, res_o.mispredict}), 64'd0);
    chk({tag, ".rob_idx"},   64'(rob_idx_o), 64'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    valid_i       = 1'b0;
    res_ready_i   = 1'b1;
    branch_type_i = 3'd0;
    rs1_value_i   = '0;
    rs2_value_i   = '0;
    pc_i          = '0;
    imm_i         = '0;
    pred_taken_i  = 1'b0;
    pred_target_i = '0;
    rob_idx_i     = '0;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk_i);
    chk("rst.ready", 64'(ready_o), 64'd0);
    chk_empty("rst");
    rst_i = 1'b0;
    #1;
    chk("post_rst.ready", 64'(ready_o), 64'd1);

    // ---------------- correct prediction BEQ ----------------
    @(negedge clk_i);
    drive(3'd0, 64'd5, 64'd5, 64'h1000, 13'h010, 1'b1, 64'h1010, 2'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("beq", 64'h1000, 64'h1010, 1'b1, 1'b0, 2'd1);
    @(negedge clk_i);
    chk_empty("beq_drained");

    // ---------------- signed vs unsigned ----------------
    drive(3'd2, '1, 64'd1, 64'h2000, 13'h020, 1'b1, 64'h2020, 2'd2);
    @(negedge clk_i);
    chk_head("blt", 64'h2000, 64'h2020, 1'b1, 1'b0, 2'd2);
    // Pushed while BLT pops: count stays 1 and BLTU becomes head.
    drive(3'd4, '1, 64'd1, 64'h2000, 13'h020, 1'b1, 64'h2020, 2'd3);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("bltu", 64'h2000, 64'h2004, 1'b0, 1'b1, 2'd3);
    @(negedge clk_i);
    chk("bltu_drained.valid", 64'(res_valid_o), 64'd0);

    // ---------------- wrap and negative offsets ----------------
    drive(3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 13'h010, 1'b1, 64'h8, 2'd0);
    @(negedge clk_i);
    chk_head("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 1'b1, 1'b0, 2'd0);
    drive(3'd3, 64'd3, 64'd3, 64'h1800, 13'h1000, 1'b0, 64'h0, 2'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("neg_imm_bge", 64'h1800, 64'h800, 1'b1, 1'b1, 2'd1);
    @(negedge clk_i);

    // ---------------- BGEU unsigned false ----------------
    drive(3'd5, 64'd1, '1, 64'h3100, 13'h040, 1'b0, 64'h0, 2'd2);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("bgeu", 64'h3100, 64'h3104, 1'b0, 1'b0, 2'd2);
    @(negedge clk_i);

    // ---------------- back-pressure ----------------
    res_ready_i = 1'b0;
    drive(3'd1, 64'd1, 64'd2, 64'h4000, 13'h008, 1'b1, 64'h4008, 2'd0);
    @(negedge clk_i);
    chk("bp.ready_after1", 64'(ready_o), 64'd1);
    chk("bp.head0", 64'(rob_idx_o), 64'd0);
    // Wrong predicted target on a taken branch -> mispredict.
    drive(3'd1, 64'd1, 64'd2, 64'h4100, 13'h008, 1'b1, 64'h4200, 2'd1);
    @(negedge clk_i);
    chk("bp.ready_after2", 64'(ready_o), 64'd0);
    drive(3'd1, 64'd7, 64'd9, 64'h4200, 13'h1FF8, 1'b1, 64'h41F8, 2'd2);
    @(negedge clk_i);
    chk("bp.held_ready", 64'(ready_o), 64'd0);
    chk_head("bp.head_still0", 64'h4000, 64'h4008, 1'b1, 1'b0, 2'd0);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    chk_head("bp.head1", 64'h4100, 64'h4108, 1'b1, 1'b1, 2'd1);
    chk("bp.ready_freed", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("bp.head2", 64'h4200, 64'h41F8, 1'b1, 1'b0, 2'd2);
    @(negedge clk_i);
    chk("bp.drained", 64'(res_valid_o), 64'd0);

    // ---------------- flush with 2 held ----------------
    res_ready_i = 1'b0;
    drive(3'd0, 64'd1, 64'd1, 64'h5000, 13'h010, 1'b1, 64'h5010, 2'd1);
    @(negedge clk_i);
    drive(3'd0, 64'd1, 64'd1, 64'h5100, 13'h010, 1'b1, 64'h5110, 2'd2);
    @(negedge clk_i);
    chk("fl.full_ready", 64'(ready_o), 64'd0);
    flush_i     = 1'b1;
    res_ready_i = 1'b1;
    drive(3'd0, 64'd1, 64'd1, 64'h5200, 13'h010, 1'b1, 64'h5210, 2'd3);
    #1;
    chk("fl.ready_during_flush", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk_empty("fl.full");
    chk("fl.ready_after", 64'(ready_o), 64'd1);

    // ---------------- flush with accepted concurrent input ----------------
    res_ready_i = 1'b0;
    drive(3'd0, 64'd1, 64'd1, 64'h6000, 13'h010, 1'b1, 64'h6010, 2'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    drive(3'd0, 64'd1, 64'd1, 64'h6100, 13'h010, 1'b1, 64'h6110, 2'd2);
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk_empty("fl.accept");
    @(negedge clk_i);
    chk("fl.accept_never", 64'(res_valid_o), 64'd0);

    // ---------------- reset mid-operation ----------------
    drive(3'd0, 64'd1, 64'd1, 64'h7000, 13'h010, 1'b1, 64'h7010, 2'd1);
    @(negedge clk_i);
    drive(3'd0, 64'd1, 64'd1, 64'h7100, 13'h010, 1'b1, 64'h7110, 2'd2);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("mr.held", 64'(res_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("mr.ready_in_rst", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    chk_empty("mr");
    rst_i = 1'b0;
    res_ready_i = 1'b1;
    #1;
    chk("mr.ready_after", 64'(ready_o), 64'd1);

    // ---------------- illegal type code 6 ----------------
    @(negedge clk_i);
    drive(3'd6, 64'd4, 64'd4, 64'h3000, 13'h040, 1'b0, 64'h0, 2'd3);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_head("type6", 64'h3000, 64'h3004, 1'b0, 1'b0, 2'd3);
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
